// File: rtl/fifo_burst_if.sv
// Request/data/flag bundle between the burst controller (master) and the
// single-clock FIFO instance (slave).
interface fifo_burst_if #(
    parameter int DATA_W  = 8,
    parameter int USEDW_W = 8
);
    logic               fifo_wr_req;
    logic [DATA_W-1:0]  fifo_wr_data;
    logic               fifo_rd_req;
    logic               fifo_full;
    logic               fifo_empty;
    logic [USEDW_W-1:0] fifo_usedw;
    logic [DATA_W-1:0]  fifo_rd_data;

    modport master (
        output fifo_wr_req, fifo_wr_data, fifo_rd_req,
        input  fifo_full, fifo_empty, fifo_usedw, fifo_rd_data
    );

    modport slave (
        input  fifo_wr_req, fifo_wr_data, fifo_rd_req,
        output fifo_full, fifo_empty, fifo_usedw, fifo_rd_data
    );
endinterface

// File: rtl/fifo_burst_ctrl.sv
// Fill/drain sequencer for a non-show-ahead scfifo: paced incrementing writes up
// to a watermark or full, one drain burst to empty, with in-line read-data check.
module fifo_burst_ctrl #(
    parameter int DATA_W      = 8,
    parameter int USEDW_W     = 8,
    parameter int WR_INTERVAL = 4,
    parameter int HIGH_WM     = 255
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             enable,
    fifo_burst_if.master     fifo,
    output logic [1:0]       state,
    output logic [15:0]      burst_cnt,
    output logic             err
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int                 PCNT_W    = (WR_INTERVAL > 2) ? $clog2(WR_INTERVAL) : 1;
    localparam logic [PCNT_W-1:0]  PCNT_LAST = PCNT_W'(WR_INTERVAL - 1);
    localparam logic [USEDW_W-1:0] HIGH_WM_V = USEDW_W'(HIGH_WM);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [PCNT_W-1:0]  pcnt_r;
    logic [DATA_W-1:0]  wr_data_r;
    logic [DATA_W-1:0]  exp_data_r;
    logic               rd_vld_r;
    logic [15:0]        burst_cnt_r;
    logic               err_r;
    logic               wr_req_s;
    logic               rd_req_s;
    logic               at_wm_s;
    logic               drain_done_s;

    // Next-state decode and request strobes; usedw wrapping to 0 at full is covered by fifo_full.
    always_comb begin
        state_nxt_s  = state_r;
        wr_req_s     = 1'b0;
        rd_req_s     = 1'b0;
        drain_done_s = 1'b0;
        at_wm_s      = fifo.fifo_full | (fifo.fifo_usedw >= HIGH_WM_V);
        case (state_r)
            ST_IDLE: begin
                if (enable) state_nxt_s = ST_FILL;
                else        state_nxt_s = ST_IDLE;
            end
            ST_FILL: begin
                wr_req_s = (pcnt_r == {PCNT_W{1'b0}}) & ~at_wm_s & enable;
                if (at_wm_s || !enable) state_nxt_s = ST_DRAIN;
                else                    state_nxt_s = ST_FILL;
            end
            ST_DRAIN: begin
                rd_req_s = ~fifo.fifo_empty;
                if (fifo.fifo_empty) begin
                    drain_done_s = 1'b1;
                    if (enable) state_nxt_s = ST_FILL;
                    else        state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, write pacing, write data and completed-burst counter.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r     <= ST_IDLE;
            pcnt_r      <= {PCNT_W{1'b0}};
            wr_data_r   <= {DATA_W{1'b0}};
            burst_cnt_r <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_FILL) && (state_nxt_s == ST_FILL)) begin
                pcnt_r <= (pcnt_r == PCNT_LAST) ? {PCNT_W{1'b0}} : pcnt_r + {{(PCNT_W-1){1'b0}}, 1'b1};
            end else begin
                pcnt_r <= {PCNT_W{1'b0}};
            end
            if (wr_req_s) wr_data_r <= wr_data_r + {{(DATA_W-1){1'b0}}, 1'b1};
            if (drain_done_s) burst_cnt_r <= burst_cnt_r + 16'd1;
        end
    end

    // Read-data checker: q is valid the cycle after rd_req and must follow the write sequence.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_vld_r   <= 1'b0;
            exp_data_r <= {DATA_W{1'b0}};
            err_r      <= 1'b0;
        end else begin
            rd_vld_r <= rd_req_s;
            if (rd_vld_r) begin
                exp_data_r <= exp_data_r + {{(DATA_W-1){1'b0}}, 1'b1};
                if (fifo.fifo_rd_data != exp_data_r) err_r <= 1'b1;
            end
        end
    end

    assign fifo.fifo_wr_req  = wr_req_s;
    assign fifo.fifo_rd_req  = rd_req_s;
    assign fifo.fifo_wr_data = wr_data_r;
    assign state             = state_r;
    assign burst_cnt         = burst_cnt_r;
    assign err               = err_r;
endmodule
